// File: rtl/l1_dcache_pkg.sv
// Shared definitions for the L1 data-cache load/store front end:
// funct3 encodings, FSM state encoding, latched request and access legality decode.
package l1_dcache_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_RD   = 3'd1;
   localparam logic [2:0] ST_CAP  = 3'd2;
   localparam logic [2:0] ST_WR   = 3'd3;
   localparam logic [2:0] ST_ERR  = 3'd4;

   typedef enum logic [2:0] {
      IDLE = ST_IDLE,
      RD   = ST_RD,
      CAP  = ST_CAP,
      WR   = ST_WR,
      ERR  = ST_ERR
   } state_t;

   typedef struct packed {
      logic        store;
      logic [2:0]  funct3;
      logic [1:0]  off;
      logic [31:0] wdata;
   } req_t;

   // Stores only exist as B/H/W; unsigned variants are load-only.
   function automatic logic req_bad(input logic store, input logic [2:0] funct3,
                                    input logic [1:0] off);
      logic illegal, misaligned;
      if (store)
         illegal = !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W);
      else
         illegal = !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W ||
                     funct3 == F3_BU || funct3 == F3_HU);
      misaligned = ((funct3 == F3_H || funct3 == F3_HU) && off[0]) ||
                   (funct3 == F3_W && off != 2'b00);
      return illegal || misaligned;
   endfunction

endpackage

// File: rtl/dcache_lane_align.sv
// Byte-lane alignment: load lane select with sign/zero extension, and
// sub-word store merge into the word read back from the cache.
module dcache_lane_align
   import l1_dcache_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  off,
   input  logic [31:0] rd,
   input  logic [31:0] wdata,
   output logic [31:0] ld_data,
   output logic [31:0] st_data
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   always_comb begin
      lane_b = rd[{off, 3'b000} +: 8];
      lane_h = off[1] ? rd[31:16] : rd[15:0];
      case (funct3)
         F3_B:    ld_data = {{24{lane_b[7]}}, lane_b};
         F3_BU:   ld_data = {24'h0, lane_b};
         F3_H:    ld_data = {{16{lane_h[15]}}, lane_h};
         F3_HU:   ld_data = {16'h0, lane_h};
         default: ld_data = rd;
      endcase
   end

   always_comb begin
      st_data = rd;
      case (funct3)
         F3_B:    st_data[{off, 3'b000} +: 8]     = wdata[7:0];
         F3_H:    st_data[{off[1], 4'b0000} +: 16] = wdata[15:0];
         default: st_data = wdata;
      endcase
   end

endmodule

// File: rtl/l1_dcache_ctrl.sv
// Load/store front end for a single-port synchronous-read L1 data cache:
// word reads with extension, read-modify-write for sub-word stores, error reporting.
module l1_dcache_ctrl
   import l1_dcache_pkg::*;
#(
   parameter  int N      = 1024,
   localparam int ADDR_W = $clog2(N)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_store,
   input  logic [2:0]        req_funct3,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] cache_a,
   output logic [31:0]       cache_wd,
   output logic              cache_we,
   input  logic [31:0]       cache_rd
);

   state_t            state;
   req_t              req;
   logic [31:0]       ld_data, st_data;
   logic [ADDR_W-1:0] req_idx;
   logic              unused_addr;

   // Addresses wrap modulo the cache size; the upper bits are dropped on purpose.
   assign req_idx     = req_addr[ADDR_W+1:2];
   assign unused_addr = ^(req_addr >> (ADDR_W + 2));

   dcache_lane_align u_align (
      .funct3  (req.funct3),
      .off     (req.off),
      .rd      (cache_rd),
      .wdata   (req.wdata),
      .ld_data (ld_data),
      .st_data (st_data)
   );

   // Read data is only valid during CAP, so the load result bypasses the register.
   assign rsp_rdata = (state == CAP && !req.store) ? ld_data : 32'h0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         req       <= '0;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         cache_a   <= '0;
         cache_wd  <= '0;
         cache_we  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               req       <= '{store: req_store, funct3: req_funct3,
                              off: req_addr[1:0], wdata: req_wdata};
               req_ready <= 1'b0;
               if (req_bad(req_store, req_funct3, req_addr[1:0])) begin
                  state     <= ERR;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
               end else if (req_store && req_funct3 == F3_W) begin
                  state     <= WR;
                  cache_a   <= req_idx;
                  cache_wd  <= req_wdata;
                  cache_we  <= 1'b1;
                  rsp_valid <= 1'b1;
               end else begin
                  state   <= RD;
                  cache_a <= req_idx;
               end
            end
            RD: begin
               state     <= CAP;
               rsp_valid <= !req.store;
            end
            CAP: if (req.store) begin
               state     <= WR;
               cache_wd  <= st_data;
               cache_we  <= 1'b1;
               rsp_valid <= 1'b1;
            end else begin
               state     <= IDLE;
               rsp_valid <= 1'b0;
               req_ready <= 1'b1;
            end
            default: begin
               state     <= IDLE;
               rsp_valid <= 1'b0;
               rsp_err   <= 1'b0;
               cache_we  <= 1'b0;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_l1_dcache_ctrl.sv
// Bench for l1_dcache_ctrl: BRAM model, reference memory scoreboard checked every
// cycle, and directed requests with hand-computed results.
module tb_l1_dcache_ctrl;

   localparam int N  = 1024;
   localparam int AW = 10;

   logic          clk, rst;
   logic          req_valid, req_ready, req_store;
   logic [2:0]    req_funct3;
   logic [31:0]   req_addr, req_wdata;
   logic          rsp_valid, rsp_err;
   logic [31:0]   rsp_rdata;
   logic [AW-1:0] cache_a;
   logic [31:0]   cache_wd, cache_rd;
   logic          cache_we;

   logic [31:0] ram     [N];
   logic [31:0] ref_mem [N];
   int n_chk  = 0;
   int n_fail = 0;

   l1_dcache_ctrl #(.N(N)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .cache_a(cache_a), .cache_wd(cache_wd), .cache_we(cache_we), .cache_rd(cache_rd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous-read single-port BRAM.
   always @(posedge clk) begin
      if (cache_we) ram[cache_a] <= cache_wd;
      cache_rd <= ram[cache_a];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit model_err(input logic st, input logic [2:0] f3, input logic [1:0] off);
      int size;
      case (f3)
         3'd0, 3'd4: size = 1;
         3'd1, 3'd5: size = 2;
         3'd2:       size = 4;
         default:    size = 0;
      endcase
      if (size == 0) return 1'b1;
      if (st && size != 4 && f3 >= 3'd4) return 1'b1;
      return (int'(off) % size) != 0;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] w);
      int o, v;
      o = int'(off);
      case (f3)
         3'd0, 3'd4: begin
            v = int'((w >> (8 * o)) & 32'hFF);
            if (f3 == 3'd0 && v >= 128) v -= 256;
         end
         3'd1, 3'd5: begin
            v = int'((w >> (8 * o)) & 32'hFFFF);
            if (f3 == 3'd1 && v >= 32768) v -= 65536;
         end
         default: v = int'(w);
      endcase
      return 32'(v);
   endfunction

   function automatic logic [31:0] model_store(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] w, input logic [31:0] wd);
      logic [31:0] mask;
      int o;
      o = int'(off);
      if (f3 == 3'd2) return wd;
      mask = ((f3 == 3'd0) ? 32'hFF : 32'hFFFF) << (8 * o);
      return (w & ~mask) | ((wd << (8 * o)) & mask);
   endfunction

   // Scoreboard: one outstanding request, checked on every cycle.
   bit          m_active, m_err, m_write;
   int          m_k, m_lat, m_idx;
   logic [31:0] m_rd, m_wd, m_ca;

   always @(negedge clk) begin
      if (rst) begin
         m_active = 1'b0;
         chk("rst_ready", 32'(req_ready), 32'd1);
         chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
         chk("rst_rsp_err", 32'(rsp_err), 32'd0);
         chk("rst_rdata", rsp_rdata, 32'd0);
         chk("rst_cache_we", 32'(cache_we), 32'd0);
         chk("rst_cache_a", 32'(cache_a), 32'd0);
         chk("rst_cache_wd", cache_wd, 32'd0);
      end else if (m_active) begin
         m_k++;
         chk("ready_busy", 32'(req_ready), 32'd0);
         chk("rsp_valid", 32'(rsp_valid), 32'(m_k == m_lat));
         chk("cache_we", 32'(cache_we), 32'(m_k == m_lat && m_write));
         if (m_k == m_lat) begin
            chk("rsp_err", 32'(rsp_err), 32'(m_err));
            chk("rsp_rdata", rsp_rdata, m_rd);
            if (m_write) begin
               chk("cache_a", 32'(cache_a), 32'(m_idx));
               chk("cache_wd", cache_wd, m_wd);
               ref_mem[m_idx] = m_wd;
            end else if (m_err) begin
               chk("err_cache_a", 32'(cache_a), m_ca);
            end
            m_active = 1'b0;
         end
      end else begin
         chk("ready_idle", 32'(req_ready), 32'd1);
         chk("rsp_valid_idle", 32'(rsp_valid), 32'd0);
         chk("cache_we_idle", 32'(cache_we), 32'd0);
         if (req_valid) begin
            m_idx   = int'(req_addr[AW+1:2]);
            m_err   = model_err(req_store, req_funct3, req_addr[1:0]);
            m_ca    = 32'(cache_a);
            m_write = 1'b0;
            m_rd    = 32'h0;
            m_wd    = 32'h0;
            if (m_err) m_lat = 1;
            else if (req_store) begin
               m_write = 1'b1;
               m_lat   = (req_funct3 == 3'd2) ? 1 : 3;
               m_wd    = model_store(req_funct3, req_addr[1:0], ref_mem[m_idx], req_wdata);
            end else begin
               m_lat = 2;
               m_rd  = model_load(req_funct3, req_addr[1:0], ref_mem[m_idx]);
            end
            m_active = 1'b1;
            m_k      = 0;
         end
      end
   end

   // Issue one request, return the response seen and the cache write in that cycle.
   task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rd, output logic er,
                         output int lat, output logic we, output logic [31:0] wa,
                         output logic [31:0] wdo);
      int n;
      req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
      n = 0;
      while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
      chk("accept_wait", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 10) begin @(posedge clk); #1; lat++; end
      chk("rsp_wait", 32'(rsp_valid), 32'd1);
      rd = rsp_rdata; er = rsp_err; we = cache_we; wa = 32'(cache_a); wdo = cache_wd;
   endtask

   logic [31:0] rd, wa, wdo;
   logic        er, we;
   int          lat;

   initial begin
      rst = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0;
      req_addr = 32'h0; req_wdata = 32'h0;
      for (int i = 0; i < N; i++) ram[i] = 32'h0;
      ram[0] = 32'h80FF7F01;
      ram[5] = 32'hCAFEF00D;
      ram[8] = 32'h11223344;
      for (int i = 0; i < N; i++) ref_mem[i] = ram[i];
      #2 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;

      do_req(1, 3'd2, 32'h10, 32'hDEADBEEF, rd, er, lat, we, wa, wdo);
      chk("sw_lat", 32'(lat), 32'd1);
      chk("sw_we", 32'(we), 32'd1);
      chk("sw_addr", wa, 32'd4);
      chk("sw_data", wdo, 32'hDEADBEEF);
      do_req(0, 3'd2, 32'h10, 32'h0, rd, er, lat, we, wa, wdo);
      chk("lw_lat", 32'(lat), 32'd2);
      chk("lw_data", rd, 32'hDEADBEEF);

      do_req(0, 3'd0, 32'h3, 32'h0, rd, er, lat, we, wa, wdo);
      chk("lb_3", rd, 32'hFFFFFF80);
      do_req(0, 3'd4, 32'h3, 32'h0, rd, er, lat, we, wa, wdo);
      chk("lbu_3", rd, 32'h00000080);
      do_req(0, 3'd1, 32'h2, 32'h0, rd, er, lat, we, wa, wdo);
      chk("lh_2", rd, 32'hFFFF80FF);
      do_req(0, 3'd5, 32'h0, 32'h0, rd, er, lat, we, wa, wdo);
      chk("lhu_0", rd, 32'h00007F01);

      do_req(1, 3'd0, 32'h21, 32'h000000AB, rd, er, lat, we, wa, wdo);
      chk("sb_lat", 32'(lat), 32'd3);
      chk("sb_we", 32'(we), 32'd1);
      chk("sb_addr", wa, 32'd8);
      chk("sb_data", wdo, 32'h1122AB44);
      do_req(0, 3'd2, 32'h20, 32'h0, rd, er, lat, we, wa, wdo);
      chk("sb_readback", rd, 32'h1122AB44);

      do_req(0, 3'd2, 32'h6, 32'h0, rd, er, lat, we, wa, wdo);
      chk("lw_mis_lat", 32'(lat), 32'd1);
      chk("lw_mis_err", 32'(er), 32'd1);
      chk("lw_mis_we", 32'(we), 32'd0);
      do_req(1, 3'd1, 32'h3, 32'h1234, rd, er, lat, we, wa, wdo);
      chk("sh_mis_err", 32'(er), 32'd1);
      chk("sh_mis_we", 32'(we), 32'd0);
      do_req(1, 3'd4, 32'h40, 32'h55, rd, er, lat, we, wa, wdo);
      chk("st_f3_err", 32'(er), 32'd1);
      chk("st_f3_rdata", rd, 32'h0);

      do_req(1, 3'd2, 32'h1000, 32'h5, rd, er, lat, we, wa, wdo);
      chk("wrap_addr", wa, 32'd0);
      chk("wrap_err", 32'(er), 32'd0);
      do_req(0, 3'd2, 32'h0, 32'h0, rd, er, lat, we, wa, wdo);
      chk("wrap_load", rd, 32'h00000005);

      // Abandon an SB read-modify-write while it sits in the capture cycle.
      req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'd0;
      req_addr = 32'h15; req_wdata = 32'h99;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1 chk("rmw_rst_we", 32'(cache_we), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1 chk("rmw_rst_ready", 32'(req_ready), 32'd1);
      chk("rmw_rst_mem", ram[5], 32'hCAFEF00D);
      do_req(0, 3'd2, 32'h14, 32'h0, rd, er, lat, we, wa, wdo);
      chk("rmw_rst_load", rd, 32'hCAFEF00D);

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
